bullet_slot_arbiter: RTL and testbench

//   Shares the bullet engine's NUM_SLOTS bullet slots between player 1 and player 2.
//   - Turns fire-button edges into launch requests.
//   - Enforces a per-player cooldown and a per-player bullet cap.
//   - Round-robins simultaneous requests.
//   - Issues one launch at a time to the bullet engine over a valid/ready handshake.

---
 rtl/bullet_slot_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bullet_slot_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_slot_arbiter.sv
// Shares the bullet engine's slots between two players: fire-edge requests, cooldown,
// per-player cap, round-robin tie break and a single registered launch handshake.
module bullet_slot_arbiter #(
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_PER_PLAYER  = 2,
  parameter int COOLDOWN_FRAMES = 15,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 frame_tick_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 fire_p1_i,
  input  logic                 fire_p2_i,
  input  logic [NUM_SLOTS-1:0] slot_release_i,
  input  logic                 launch_ready_i,
  output logic                 launch_valid_o,
  output logic [SW-1:0]        launch_slot_o,
  output logic                 launch_owner_o,
  output logic [NUM_SLOTS-1:0] slot_busy_o,
  output logic [CW-1:0]        active_p1_o,
  output logic [CW-1:0]        active_p2_o
);

  // Handshake: launch_valid_o rises with slot/owner already stable; they stay
  // unchanged until a cycle with launch_valid_o && launch_ready_i, after which
  // valid drops for at least one cycle before the next launch.

  typedef enum logic {S_IDLE = 1'b0, S_LAUNCH = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic                      valid_q, valid_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic                      lown_q, lown_d;
  logic                      last_q, last_d;
  logic [1:0]                fire_q;
  logic [1:0]                pend_q, pend_d;
  logic [1:0][7:0]           cool_q, cool_d;
  logic [1:0][CW-1:0]        cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]      busy_q, busy_d;
  logic [NUM_SLOTS-1:0]      owner_q, owner_d;

  logic                      free_any;
  logic [SW-1:0]             free_idx;
  logic [1:0]                elig;
  logic                      grant;
  logic                      gsel;
  logic [1:0]                gnt_mask;
  logic [1:0]                rise;
  logic [NUM_SLOTS-1:0]      rel_eff;
  logic [1:0][CW-1:0]        rel_cnt;

  // Lowest-index free slot, taken from the busy bits before this cycle's releases.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        free_any = 1'b1;
        free_idx = SW'(k);
      end
    end
  end

  always_comb begin
    for (int x = 0; x < 2; x++) begin
      elig[x] = pend_q[x] && (cool_q[x] == 8'd0) &&
                (cnt_q[x] < CW'(MAX_PER_PLAYER)) && free_any;
    end
  end

  // FSM: IDLE grants at most one player per visit, LAUNCH waits for the engine.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gsel    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          grant   = 1'b1;
          gsel    = (&elig) ? ~last_q : elig[1];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (launch_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_LAUNCH);
  end

  assign gnt_mask = grant ? (2'b01 << gsel) : 2'b00;
  assign rise     = {fire_p2_i, fire_p1_i} & ~fire_q;

  // The slot being launched cannot be released until the handshake completes.
  always_comb begin
    rel_cnt = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      rel_eff[k] = slot_release_i[k] && busy_q[k] &&
                   !(valid_q && (slot_q == SW'(k)));
      if (rel_eff[k]) rel_cnt[owner_q[k]] = rel_cnt[owner_q[k]] + CW'(1);
    end
  end

  always_comb begin
    busy_d  = busy_q & ~rel_eff;
    owner_d = owner_q;
    slot_d  = slot_q;
    lown_d  = lown_q;
    last_d  = last_q;
    if (grant) begin
      busy_d[free_idx]  = 1'b1;
      owner_d[free_idx] = gsel;
      slot_d            = free_idx;
      lown_d            = gsel;
      last_d            = gsel;
    end
    for (int x = 0; x < 2; x++) begin
      cnt_d[x] = cnt_q[x] + CW'(gnt_mask[x]) - rel_cnt[x];
      if (gnt_mask[x])
        cool_d[x] = 8'(COOLDOWN_FRAMES);
      else if (frame_tick_i && (cool_q[x] != 8'd0))
        cool_d[x] = cool_q[x] - 8'd1;
      else
        cool_d[x] = cool_q[x];
    end
    pend_d = enable_i ? ((pend_q | rise) & ~gnt_mask) : 2'b00;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      slot_q  <= '0;
      lown_q  <= 1'b0;
      last_q  <= 1'b1;
      fire_q  <= 2'b00;
      pend_q  <= 2'b00;
      cool_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      owner_q <= '0;
    end else if (clear_i) begin
      // Round reset keeps the round-robin pointer so fairness carries across rounds.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      slot_q  <= '0;
      lown_q  <= 1'b0;
      fire_q  <= 2'b00;
      pend_q  <= 2'b00;
      cool_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
      lown_q  <= lown_d;
      last_q  <= last_d;
      fire_q  <= {fire_p2_i, fire_p1_i};
      pend_q  <= pend_d;
      cool_q  <= cool_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign launch_valid_o = valid_q;
  assign launch_slot_o  = slot_q;
  assign launch_owner_o = lown_q;
  assign slot_busy_o    = busy_q;
  assign active_p1_o    = cnt_q[0];
  assign active_p2_o    = cnt_q[1];

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Bench for bullet_slot_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural slot/player model.
module tb_bullet_slot_arbiter;
  localparam int NS   = 4;
  localparam int MAXP = 2;
  localparam int COOL = 15;
  localparam int SW   = 2;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_tick, enable, clear, fire1, fire2, ready;
  logic [NS-1:0] rel;
  logic          launch_valid, launch_owner;
  logic [SW-1:0] launch_slot;
  logic [NS-1:0] slot_busy;
  logic [CW-1:0] act_p1, act_p2;

  int n_checks = 0;
  int n_errors = 0;

  bullet_slot_arbiter #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(MAXP), .COOLDOWN_FRAMES(COOL)) dut (
    .clk_i(clk), .reset_ni(rst_n), .frame_tick_i(frame_tick), .enable_i(enable),
    .clear_i(clear), .fire_p1_i(fire1), .fire_p2_i(fire2), .slot_release_i(rel),
    .launch_ready_i(ready), .launch_valid_o(launch_valid), .launch_slot_o(launch_slot),
    .launch_owner_o(launch_owner), .slot_busy_o(slot_busy), .active_p1_o(act_p1),
    .active_p2_o(act_p2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit           m_pend[2];
  int           m_cool[2];
  int           m_cnt[2];
  bit           m_prev[2];
  bit           m_busy[NS];
  int           m_owner[NS];
  int           m_last;
  bit           m_launch;
  int           m_slot;
  int           m_own;
  logic [SW:0]  exp_q[$];

  task automatic model_clear(input bit full);
    for (int x = 0; x < 2; x++) begin
      m_pend[x] = 0; m_cool[x] = 0; m_cnt[x] = 0; m_prev[x] = 0;
    end
    for (int k = 0; k < NS; k++) begin
      m_busy[k] = 0; m_owner[k] = 0;
    end
    m_launch = 0; m_slot = 0; m_own = 0;
    if (full) begin
      m_last = 1;
      exp_q.delete();
    end
  endtask

  task automatic model_step();
    int g, s;
    bit f[2];
    f[0] = fire1; f[1] = fire2;
    g = -1; s = -1;
    if (!rst_n) begin
      model_clear(1);
      return;
    end
    if (clear) begin
      model_clear(0);
      return;
    end
    if (!m_launch) begin
      bit el[2];
      for (int k = NS - 1; k >= 0; k--) if (!m_busy[k]) s = k;
      for (int x = 0; x < 2; x++)
        el[x] = m_pend[x] && m_cool[x] == 0 && m_cnt[x] < MAXP && s >= 0;
      if (el[0] && el[1]) g = 1 - m_last;
      else if (el[0]) g = 0;
      else if (el[1]) g = 1;
    end
    for (int k = 0; k < NS; k++)
      if (rel[k] && m_busy[k] && !(m_launch && m_slot == k)) begin
        m_busy[k] = 0;
        m_cnt[m_owner[k]]--;
      end
    if (m_launch && ready) m_launch = 0;
    for (int x = 0; x < 2; x++) begin
      if (g == x) m_cool[x] = COOL;
      else if (frame_tick && m_cool[x] > 0) m_cool[x]--;
      if (!enable || g == x) m_pend[x] = 0;
      else if (f[x] && !m_prev[x]) m_pend[x] = 1;
      m_prev[x] = f[x];
    end
    if (g >= 0) begin
      m_busy[s] = 1; m_owner[s] = g; m_cnt[g]++;
      m_last = g; m_launch = 1; m_slot = s; m_own = g;
      exp_q.push_back({g[0], s[SW-1:0]});
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic prev_v = 1'b0;
  always @(posedge clk) begin
    logic [NS-1:0] eb;
    logic [SW:0]   e;
    model_step();
    #1;
    for (int k = 0; k < NS; k++) eb[k] = m_busy[k];
    check("mdl_valid", 32'(launch_valid), 32'(m_launch));
    if (launch_valid && m_launch) begin
      check("mdl_slot", 32'(launch_slot), m_slot);
      check("mdl_owner", 32'(launch_owner), m_own);
    end
    check("mdl_busy", 32'(slot_busy), 32'(eb));
    check("mdl_act_p1", 32'(act_p1), m_cnt[0]);
    check("mdl_act_p2", 32'(act_p2), m_cnt[1]);
    if (launch_valid && !prev_v) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL launch_unexpected: got launch slot %0d owner %0d, required none",
                 launch_slot, launch_owner);
      end else begin
        e = exp_q.pop_front();
        if ({launch_owner, launch_slot} !== e) begin
          n_errors++;
          $display("FAIL launch_seq: got %0h expected %0h", {launch_owner, launch_slot}, e);
        end
      end
    end
    prev_v = launch_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
  endtask

  task automatic do_clear();
    fire1 = 1'b0; fire2 = 1'b0; rel = '0;
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b1; clear = 1'b0;
    fire1 = 1'b0; fire2 = 1'b0; ready = 1'b1; rel = '0;
    cyc(3);
    check("rst_valid", 32'(launch_valid), 0);
    check("rst_slot", 32'(launch_slot), 0);
    check("rst_owner", 32'(launch_owner), 0);
    check("rst_busy", 32'(slot_busy), 0);
    check("rst_act", 32'({act_p2, act_p1}), 0);
    rst_n = 1'b1; cyc(1);

    // single P1 launch with ready high
    fire1 = 1'b1; cyc(1);
    check("t1_valid_early", 32'(launch_valid), 0);
    cyc(1);
    check("t1_valid", 32'(launch_valid), 1);
    check("t1_slot", 32'(launch_slot), 0);
    check("t1_owner", 32'(launch_owner), 0);
    check("t1_act_p1", 32'(act_p1), 1);
    check("t1_busy", 32'(slot_busy), 4'b0001);
    fire1 = 1'b0; cyc(2);

    // simultaneous requests: P1 then P2, next tie back to P1
    do_reset();
    fire1 = 1'b1; fire2 = 1'b1; cyc(2);
    check("t2_first_owner", 32'(launch_owner), 0);
    check("t2_first_slot", 32'(launch_slot), 0);
    cyc(2);
    check("t2_second_valid", 32'(launch_valid), 1);
    check("t2_second_owner", 32'(launch_owner), 1);
    check("t2_second_slot", 32'(launch_slot), 1);
    fire1 = 1'b0; fire2 = 1'b0; cyc(2);
    do_clear();
    fire1 = 1'b1; fire2 = 1'b1; cyc(2);
    check("t2_tie_owner", 32'(launch_owner), 0);
    check("t2_tie_slot", 32'(launch_slot), 0);

    // cooldown blocks a refire until the 15th frame tick
    do_clear();
    fire1 = 1'b1; cyc(2);
    check("t3_first", 32'(launch_valid), 1);
    fire1 = 1'b0; cyc(2);
    ticks(5);
    ready = 1'b0; fire1 = 1'b1; cyc(3);
    check("t3_blocked", 32'(launch_valid), 0);
    for (int k = 6; k <= 15; k++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
      check($sformatf("t3_tick%0d", k), 32'(launch_valid), (k == 15) ? 1 : 0);
    end
    ready = 1'b1; fire1 = 1'b0; cyc(2);

    // bullet cap, then released slot 0 is reused
    do_clear();
    fire1 = 1'b1; cyc(2); fire1 = 1'b0; cyc(2);
    ticks(15);
    fire1 = 1'b1; cyc(2);
    check("t4_second_slot", 32'(launch_slot), 1);
    fire1 = 1'b0; cyc(2);
    ticks(15);
    fire1 = 1'b1; cyc(4);
    check("t4_capped", 32'(launch_valid), 0);
    check("t4_cap_act", 32'(act_p1), 2);
    check("t4_cap_busy", 32'(slot_busy), 4'b0011);
    rel = 4'b0001; cyc(1); rel = '0;
    check("t4_rel_act", 32'(act_p1), 1);
    check("t4_rel_busy", 32'(slot_busy), 4'b0010);
    cyc(1);
    check("t4_reuse_valid", 32'(launch_valid), 1);
    check("t4_reuse_slot", 32'(launch_slot), 0);
    check("t4_reuse_busy", 32'(slot_busy), 4'b0011);
    fire1 = 1'b0; cyc(2);

    // engine stalls: launch held stable
    do_clear();
    ready = 1'b0; fire2 = 1'b1; cyc(2);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t5_hold", 32'({launch_valid, launch_owner, launch_slot}), 32'({1'b1, 1'b1, 2'd0}));
    end
    fire2 = 1'b0; ready = 1'b1; cyc(1);
    check("t5_drop", 32'(launch_valid), 0);
    check("t5_act_p2", 32'(act_p2), 1);
    cyc(3);
    check("t5_no_dup", 32'({launch_valid, act_p2}), 32'({1'b0, 3'd1}));

    // clear and async reset while launching
    do_clear();
    fire1 = 1'b1; cyc(2); fire1 = 1'b0; fire2 = 1'b1; cyc(3); fire2 = 1'b0;
    ticks(15);
    ready = 1'b0; fire1 = 1'b1; cyc(2);
    check("t6_busy", 32'(slot_busy), 4'b0111);
    check("t6_slot", 32'(launch_slot), 2);
    fire1 = 1'b0; clear = 1'b1; cyc(1); clear = 1'b0;
    check("t6_clr_busy", 32'(slot_busy), 0);
    check("t6_clr_act", 32'({act_p2, act_p1}), 0);
    check("t6_clr_valid", 32'(launch_valid), 0);
    fire1 = 1'b1; cyc(2);
    check("t6_relaunch", 32'(launch_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(launch_valid), 0);
    check("t6_rst_busy", 32'(slot_busy), 0);
    check("t6_rst_act", 32'(act_p1), 0);
    cyc(1); rst_n = 1'b1; fire1 = 1'b0; ready = 1'b1; cyc(2);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      fire1      = ($urandom_range(0, 3) == 0) ? ~fire1 : fire1;
      fire2      = ($urandom_range(0, 3) == 0) ? ~fire2 : fire2;
      frame_tick = 1'($urandom_range(0, 1));
      ready      = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 49) != 0);
      clear      = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NS; k++) rel[k] = ($urandom_range(0, 5) == 0);
      cyc(1);
    end
    clear = 1'b0; rel = '0; ready = 1'b1; fire1 = 1'b0; fire2 = 1'b0;
    cyc(3);
    check("end_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
